// File: rtl/m2vfptr_table_if.sv
// Decoder/display bus of the macroblock frame-pointer table.
// master = decoder + display driver side, slave = table.
interface m2vfptr_table_if #(
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
);
    logic                           dec_write;
    logic [MBX_WIDTH-1:0]           dec_mbx;
    logic [MBY_WIDTH-1:0]           dec_mby;
    logic                           dec_frame;
    logic                           dec_ready;
    logic                           mark_all;
    logic [MBX_WIDTH+MBY_WIDTH-1:0] disp_address;
    logic                           disp_updated;
    logic                           disp_number;
    logic                           disp_ack;
    logic                           busy;

    modport master (
        output dec_write, dec_mbx, dec_mby, dec_frame, mark_all, disp_address, disp_ack,
        input  dec_ready, disp_updated, disp_number, busy
    );

    modport slave (
        input  dec_write, dec_mbx, dec_mby, dec_frame, mark_all, disp_address, disp_ack,
        output dec_ready, disp_updated, disp_number, busy
    );
endinterface

// File: rtl/m2vfptr_table.sv
// Per-MB frame-pointer table: 2-stage decoder write, 1-cycle display read, toggle-pair change flags.
// Backpressure: dec_ready low and display outputs forced 0 while clearing, draining or marking.
module m2vfptr_table #(
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           soft_reset,
    m2vfptr_table_if.slave bus
);
    localparam int AW = MBX_WIDTH + MBY_WIDTH;
    localparam int N  = 1 << AW;
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_DRAIN, ST_MARK} state_t;

    state_t      state, state_nxt;
    logic [AW:0] cnt, cnt_nxt;

    logic num_mem  [N];
    logic dtog_mem [N];
    logic vtog_mem [N];

    logic          s2_vld;
    logic [AW-1:0] s2_addr;
    logic          s2_frame;
    logic          s2_dtog;

    logic          mark_vld;
    logic [AW-1:0] mark_addr;
    logic          mark_dtog;

    logic          upd_q;
    logic          num_q;
    logic [AW-1:0] shown_addr;
    logic          shown_dtog;

    logic          accept;
    logic [AW-1:0] dec_addr;
    logic          dec_dtog_rd;

    logic          nd_we;
    logic [AW-1:0] nd_wa;
    logic          num_wd;
    logic          dtog_wd;
    logic          vtog_we;
    logic [AW-1:0] vtog_wa;
    logic          vtog_wd;

    logic          rd_num;
    logic          rd_dtog;
    logic          rd_vtog;

    assign dec_addr = {bus.dec_mby, bus.dec_mbx};
    assign accept   = bus.dec_write && (state == ST_IDLE) && !soft_reset;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (soft_reset) begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt_nxt[AW]) state_nxt = ST_IDLE;
                end
                ST_IDLE: begin
                    if (bus.mark_all) state_nxt = ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Accepts stop on entry, so the only S2 write retires at this edge.
                    if (!accept) begin
                        state_nxt = ST_MARK;
                        cnt_nxt   = '0;
                    end
                end
                ST_MARK: begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt[AW]) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_CLEAR;
            endcase
        end
    end

    // Single write port per array; the owning source is fixed by state.
    always_comb begin
        nd_we   = 1'b0;
        nd_wa   = s2_addr;
        num_wd  = s2_frame;
        dtog_wd = ~s2_dtog;
        vtog_we = 1'b0;
        vtog_wa = shown_addr;
        vtog_wd = shown_dtog;
        if (!soft_reset) begin
            if (state == ST_CLEAR) begin
                nd_we   = 1'b1;
                nd_wa   = cnt[AW-1:0];
                num_wd  = 1'b0;
                dtog_wd = 1'b0;
                vtog_we = 1'b1;
                vtog_wa = cnt[AW-1:0];
                vtog_wd = 1'b0;
            end else begin
                nd_we = s2_vld;
                if (mark_vld) begin
                    vtog_we = 1'b1;
                    vtog_wa = mark_addr;
                    vtog_wd = ~mark_dtog;
                end else if (state == ST_IDLE && bus.disp_ack) begin
                    vtog_we = 1'b1;
                end
            end
        end
    end

    // Write-first reads: a same-cycle write to the looked-up entry wins.
    always_comb begin
        rd_num      = (nd_we && nd_wa == bus.disp_address) ? num_wd : num_mem[bus.disp_address];
        rd_dtog     = (nd_we && nd_wa == bus.disp_address) ? dtog_wd : dtog_mem[bus.disp_address];
        rd_vtog     = (vtog_we && vtog_wa == bus.disp_address) ? vtog_wd : vtog_mem[bus.disp_address];
        dec_dtog_rd = (nd_we && nd_wa == dec_addr) ? dtog_wd : dtog_mem[dec_addr];
    end

    always_ff @(posedge clk) begin
        if (nd_we) begin
            num_mem[nd_wa]  <= num_wd;
            dtog_mem[nd_wa] <= dtog_wd;
        end
        if (vtog_we) vtog_mem[vtog_wa] <= vtog_wd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            cnt        <= '0;
            s2_vld     <= 1'b0;
            s2_addr    <= '0;
            s2_frame   <= 1'b0;
            s2_dtog    <= 1'b0;
            mark_vld   <= 1'b0;
            mark_addr  <= '0;
            mark_dtog  <= 1'b0;
            upd_q      <= 1'b0;
            num_q      <= 1'b0;
            shown_addr <= '0;
            shown_dtog <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            s2_vld <= accept;
            if (accept) begin
                s2_addr  <= dec_addr;
                s2_frame <= bus.dec_frame;
                s2_dtog  <= dec_dtog_rd;
            end
            // Sweep read of entry k lands as a VTOG write of entry k one cycle later.
            mark_vld   <= !soft_reset && (state == ST_MARK) && !cnt[AW];
            mark_addr  <= cnt[AW-1:0];
            mark_dtog  <= dtog_mem[cnt[AW-1:0]];
            upd_q      <= rd_dtog ^ rd_vtog;
            num_q      <= rd_num;
            shown_addr <= bus.disp_address;
            shown_dtog <= rd_dtog;
        end
    end

    assign bus.busy         = (state != ST_IDLE);
    assign bus.dec_ready    = (state == ST_IDLE);
    assign bus.disp_updated = (state == ST_IDLE) && upd_q;
    assign bus.disp_number  = (state == ST_IDLE) && num_q;
endmodule

// File: tb/tb_m2vfptr_table.sv
// Bench for m2vfptr_table (N=16): directed scenarios plus random traffic, all checked each
// cycle against a write-count/ack-count model of the table.
module tb_m2vfptr_table;
    localparam int MBXW = 2;
    localparam int MBYW = 2;
    localparam int N    = 16;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_MARK = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic soft_reset = 1'b0;

    m2vfptr_table_if #(.MBX_WIDTH(MBXW), .MBY_WIDTH(MBYW)) bus ();

    m2vfptr_table #(.MBX_WIDTH(MBXW), .MBY_WIDTH(MBYW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: per-entry decoder write count and the count the display last acknowledged.
    int ver [N];
    int ackd[N];
    bit num [N];
    bit pend_vld;
    int pend_a;
    bit pend_f;
    int shown_a, shown_v;
    int phase, left;
    bit m_upd, m_num;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin ver[i] = 0; ackd[i] = 0; num[i] = 0; end
            pend_vld = 0; phase = P_CLEAR; left = N;
            m_upd = 0; m_num = 0; shown_a = 0; shown_v = 0;
        end else begin
            automatic bit was_idle = (phase == P_IDLE);
            automatic int a = int'(bus.disp_address);
            if (soft_reset) begin
                for (int i = 0; i < N; i++) begin ver[i] = 0; ackd[i] = 0; num[i] = 0; end
                pend_vld = 0; phase = P_CLEAR; left = N;
            end else begin
                if (pend_vld) begin
                    ver[pend_a]++;
                    num[pend_a] = pend_f;
                    pend_vld = 0;
                end
                if (was_idle && bus.disp_ack) ackd[shown_a] = shown_v;
                if (!was_idle) begin
                    left--;
                    if (left == 0) begin
                        if (phase == P_MARK)
                            for (int i = 0; i < N; i++) ackd[i] = ver[i] - 1;
                        phase = P_IDLE;
                    end
                end else if (bus.mark_all) begin
                    phase = P_MARK;
                    left  = N + 2;
                end
                if (was_idle && bus.dec_write) begin
                    pend_vld = 1;
                    pend_a   = int'({bus.dec_mby, bus.dec_mbx});
                    pend_f   = bus.dec_frame;
                end
            end
            m_upd   = ((ver[a] - ackd[a]) & 1) != 0;
            m_num   = num[a];
            shown_a = a;
            shown_v = ver[a];
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            automatic bit idle = (phase == P_IDLE);
            chk("busy", int'(bus.busy), int'(!idle));
            chk("dec_ready", int'(bus.dec_ready), int'(idle));
            chk("disp_updated", int'(bus.disp_updated), int'(idle && m_upd));
            chk("disp_number", int'(bus.disp_number), int'(idle && m_num));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input int a, output int upd, output int nm);
        bus.disp_address = a[3:0];
        step();
        upd = int'(bus.disp_updated);
        nm  = int'(bus.disp_number);
    endtask

    task automatic dec_wr(input int a, input bit f);
        bus.dec_write = 1'b1;
        bus.dec_mbx   = a[1:0];
        bus.dec_mby   = a[3:2];
        bus.dec_frame = f;
        step();
        bus.dec_write = 1'b0;
    endtask

    task automatic ack();
        bus.disp_ack = 1'b1;
        step();
        bus.disp_ack = 1'b0;
    endtask

    task automatic count_busy(input string name, input int exp);
        int bc = 0;
        while (bus.busy && bc < 100) begin
            bc++;
            step();
        end
        chk(name, bc, exp);
    endtask

    initial begin
        int u, v, bc;
        bus.dec_write = 0; bus.dec_mbx = 0; bus.dec_mby = 0; bus.dec_frame = 0;
        bus.mark_all = 0; bus.disp_address = 0; bus.disp_ack = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        bc = 0;
        @(negedge clk);
        while (bus.busy && bc < 100) begin
            chk("reset_dec_ready", int'(bus.dec_ready), 0);
            bc++;
            @(negedge clk);
        end
        chk("reset_busy_cycles", bc, 16);
        step();

        for (int a = 0; a < N; a++) begin
            read_at(a, u, v);
            chk("clear_upd", u, 0);
            chk("clear_num", v, 0);
        end

        dec_wr(9, 1'b1);
        read_at(9, u, v);
        chk("wr9_upd", u, 1);
        chk("wr9_num", v, 1);
        read_at(8, u, v);
        chk("other_upd", u, 0);
        read_at(9, u, v);
        ack();
        read_at(9, u, v);
        chk("ack9_upd", u, 0);
        chk("ack9_num", v, 1);

        dec_wr(9, 1'b1);
        dec_wr(9, 1'b0);
        read_at(9, u, v);
        chk("twice9_upd", u, 0);
        chk("twice9_num", v, 0);

        dec_wr(5, 1'b1);
        read_at(5, u, v);
        chk("wr5_upd", u, 1);
        dec_wr(5, 1'b0);
        ack();
        read_at(5, u, v);
        chk("late5_upd", u, 1);
        chk("late5_num", v, 0);

        bus.mark_all = 1'b1;
        step();
        bus.mark_all = 1'b0;
        chk("mark_dec_ready", int'(bus.dec_ready), 0);
        count_busy("mark_busy_cycles", 18);
        for (int a = 0; a < N; a++) begin
            read_at(a, u, v);
            chk("mark_upd", u, 1);
            ack();
        end
        for (int a = 0; a < N; a++) begin
            read_at(a, u, v);
            chk("mark_ack_upd", u, 0);
        end

        bus.mark_all = 1'b1;
        step();
        bus.mark_all  = 1'b0;
        bus.dec_write = 1'b1;
        bus.dec_mbx   = 2'd3;
        bus.dec_mby   = 2'd0;
        bus.dec_frame = 1'b1;
        repeat (8) step();
        soft_reset = 1'b1;
        step();
        soft_reset    = 1'b0;
        bus.dec_write = 1'b0;
        count_busy("soft_busy_cycles", 16);
        for (int a = 0; a < N; a++) begin
            read_at(a, u, v);
            chk("soft_upd", u, 0);
            chk("soft_num", v, 0);
        end

        for (int c = 0; c < 1500; c++) begin
            bus.dec_write    = ($urandom_range(0, 9) < 4);
            bus.dec_mbx      = 2'($urandom_range(0, 3));
            bus.dec_mby      = 2'($urandom_range(0, 3));
            bus.dec_frame    = 1'($urandom_range(0, 1));
            bus.disp_address = 4'($urandom_range(0, 15));
            bus.disp_ack     = ($urandom_range(0, 3) == 0);
            bus.mark_all     = ($urandom_range(0, 59) == 0);
            soft_reset       = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.dec_write = 0; bus.disp_ack = 0; bus.mark_all = 0; soft_reset = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/m2vfptr_table.md
Name: m2vfptr_table

Overview:
Per-macroblock frame-pointer table between the MPEG-2 decoder back end and the display drivers. The decoder posts "MB (x,y) completed into frame page p". The display driver looks up a macroblock by {mby,mbx}, reads whether it changed since it was last shown and which page holds it, then acknowledges after consuming it. Change tracking uses two toggle arrays, so each array has a single writer and no read/write conflict exists between the decoder and display sides.

Parameters:
MBX_WIDTH, 6, macroblock column index width
MBY_WIDTH, 5, macroblock row index width (N = 2^(MBX_WIDTH+MBY_WIDTH) entries)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous clear request; restarts the clear sweep
dec_write  in  1  decoder completion strobe
dec_mbx  in  MBX_WIDTH  completed MB column
dec_mby  in  MBY_WIDTH  completed MB row
dec_frame  in  1  page the MB was written to
dec_ready  out  1  decoder write accepted when high
mark_all  in  1  request: flag every MB as updated (forces full redraw)
disp_address  in  MBX_WIDTH+MBY_WIDTH  lookup address {mby,mbx}
disp_updated  out  1  MB changed since last ack
disp_number  out  1  page holding latest MB data
disp_ack  in  1  display consumed the MB currently shown on the outputs
busy  out  1  high during sweeps or drain

Behaviour:
- Storage: NUM[N], DTOG[N] (written only by the decoder path), VTOG[N] (written only by ack or sweeps). updated = DTOG ^ VTOG. Inferable as RAM.
- Reset: state CLEAR, cnt=0, busy=1, dec_ready=0, disp_updated=0, disp_number=0, pipeline valids=0.
- States: CLEAR, IDLE, DRAIN, MARK.
- CLEAR: writes NUM, DTOG and VTOG = 0 at cnt, one entry per cycle; cnt is MBX+MBY+1 bits wide. Goes to IDLE after entry N-1, so it lasts exactly N cycles. RAM contents are never assumed reset.
- IDLE: busy=0, dec_ready=1. On mark_all go to DRAIN; busy=1 and dec_ready=0 take effect from the next cycle.
- DRAIN: waits until decoder stage 2 is empty (at most 1 cycle), then enters MARK with cnt=0.
- MARK: cycle k reads DTOG[k]; cycle k+1 writes VTOG[k] = ~DTOG[k]. Pipelined, N+1 cycles total, then IDLE.
- mark_all outside IDLE is ignored.
- soft_reset takes priority over everything in any state. It drops in-flight decoder and ack operations and enters CLEAR with cnt=0.
- Decoder path, 2 stages, 1 write/cycle:
  - S1 (on accept): register address and frame; read DTOG.
  - S2: write NUM=frame, DTOG=~old.
  - If S2 writes the address S1 reads in the same cycle, forward the S2 value. Back-to-back writes to one MB toggle twice; updated parity stays correct.
- Display read: registered, latency 1. Outputs reflect disp_address from the previous cycle.
  - Write-first: a same-cycle S2 or ack write to that address is visible in the result.
  - During CLEAR, DRAIN and MARK the outputs are forced to 0.
- disp_ack: applies to the address behind the current outputs (held in a register with the captured DTOG bit). Writes VTOG[addr] = captured DTOG.
  - If the decoder toggled that MB after the capture, updated stays 1. The new data is not lost.
  - Ack is ignored outside IDLE.
  - Ack and S2 on the same address in the same cycle are legal, because they target separate arrays.
- Arithmetic: address = {mby,mbx}; cnt termination uses the carry bit; no wrap beyond N-1.

Test Plan:
- Bench uses MBX_WIDTH=2, MBY_WIDTH=2 (N=16).
- Reset release -> busy=1 for exactly 16 cycles, dec_ready=0. Then every address reads updated=0, number=0.
- dec_write mbx=1 mby=2 frame=1; next cycle disp_address=0x9 -> one cycle later updated=1, number=1. Other addresses remain 0.
- Ack that read -> re-read of 0x9 gives updated=0, number=1. Two consecutive dec_write to 0x9 -> updated=0 (parity), number = last frame.
- Read 0x5 after a decoder write; dec_write to 0x5 lands before disp_ack -> updated stays 1 after the ack.
- mark_all in IDLE -> busy until sweep done (about 18 cycles), dec_ready=0 meanwhile. Afterwards all 16 entries read updated=1; ack each -> all 0.
- soft_reset mid-MARK at cnt=7 with dec_write pending -> CLEAR restarts, 16 busy cycles, all entries 0. The pending write is dropped.
